// File: rtl/issue_rat_redeem_queue.sv
// Retire-side buffer that returns released PRFs to the RAT free list in order, accepting up to two per cycle and draining one.
// Latency: push to o_redeemed_valid is 1 cycle. Backpressure: o_retire_ready deasserts from registered occupancy when fewer than two slots remain.
module issue_rat_redeem_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               i_retire0_prf,
    input  logic                     i_retire0_valid,
    input  logic [5:0]               i_retire1_prf,
    input  logic                     i_retire1_valid,
    output logic                     o_retire_ready,
    output logic [5:0]               o_redeemed_prf,
    output logic                     o_redeemed_valid,
    input  logic                     i_redeemed_ready,
    output logic [$clog2(DEPTH):0]   o_pending_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [5:0]    mem_q [DEPTH];
    logic [5:0]    mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          push0;
    logic          push1;
    logic          pop;
    logic [AW-1:0] wr_idx1;

    // Ready looks only at registered occupancy so the free-list handshake
    // never feeds back into the retire stage combinationally.
    assign o_retire_ready   = (count_q <= CW'(DEPTH - 2));
    assign o_redeemed_valid = (count_q != '0);
    assign o_redeemed_prf   = mem_q[head_q];
    assign o_pending_count  = count_q;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        push0   = o_retire_ready && i_retire0_valid && (i_retire0_prf != 6'd0);
        push1   = o_retire_ready && i_retire1_valid && (i_retire1_prf != 6'd0);
        pop     = o_redeemed_valid && i_redeemed_ready;
        // A dropped zero-register lane 0 lets lane 1 compact into the tail slot.
        wr_idx1 = push0 ? (tail_q + AW'(1)) : tail_q;

        if (push0) begin
            mem_d[tail_q] = i_retire0_prf;
        end
        if (push1) begin
            mem_d[wr_idx1] = i_retire1_prf;
        end

        tail_d  = tail_q + AW'(push0) + AW'(push1);
        head_d  = head_q + AW'(pop);
        count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
